multi_cycle_adder: RTL

MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

---
 rtl/multi_cycle_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/multi_cycle_adder.sv
// Unsigned adder that adds CHUNK bits per cycle; optional signed overflow under MULTI_CYCLE_ADDER_OVF_EN.
// Latency: accept at edge E0, result valid after edge E0+WIDTH/CHUNK.
// Backpressure: in_ready low while busy; result held in DONE until out_ready.
module multi_cycle_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef MULTI_CYCLE_ADDER_OVF_EN
   output logic             busy,
   output logic             ovf
`else
   output logic             busy
`endif
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = CHUNK + 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   generate
      if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
         $error("multi_cycle_adder: CHUNK must divide WIDTH and be <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    slice;
   int               lo;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      lo      = int'(k_q) * CHUNK;
      slice   = {1'b0, a_q[lo +: CHUNK]} + {1'b0, b_q[lo +: CHUNK]} + CW'(carry_q);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CALC;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               k_d     = '0;
            end
         end
         CALC: begin
            sum_d[lo +: CHUNK] = slice[CHUNK-1:0];
            carry_d            = slice[CHUNK];
            k_d                = k_q + KW'(1);
            if (k_q == K_LAST) begin
               state_d = DONE;
               k_d     = '0;
               cout_d  = slice[CHUNK];
               // overflow judged on the fully assembled sum, including this last slice
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         k_q         <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         k_q         <= k_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
